isp_tpg: RTL and testbench
==========================

Name: isp_tpg

Overview:
Bayer test-pattern and sensor-timing generator. It is the source end of the pipeline's raw pixel interface (href, vsync, raw), the same interface the black-level correction stage consumes. It produces frames with programmable blanking and four patterns, and adds a per-channel black pedestal so downstream correction stages can be checked end to end. It drives the front of the ISP in place of a sensor for bring-up and regression.

Parameters:
BITS, 8, pixel width
WIDTH, 1280, active pixels per line
HEIGHT, 960, active lines per frame
BAYER, 0, CFA phase of pixel (0,0): 0 RGGB, 1 GRBG, 2 GBRG, 3 BGGR
VSYNC_CLK, 4, vsync pulse length in clocks
VFP_CLK, 8, idle clocks from vsync fall to first href
HBLANK, 16, href-low clocks after each active line

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  run frames continuously while high
pattern_mode  in  2  0 solid, 1 horizontal ramp, 2 vertical ramp, 3 checker
solid_val  in  BITS  base value for mode 0
black_r / black_gr / black_gb / black_b  in  BITS each  pedestal added per CFA channel
out_href  out  1  active-pixel qualifier
out_vsync  out  1  frame start pulse, active high
out_raw  out  BITS  pixel value; 0 whenever out_href=0
frame_done  out  1  one-clock pulse at the end of each frame
frame_cnt  out  16  completed-frame count, wraps at 0xFFFF to 0

Behaviour:
- Reset is asynchronous and active-low. During reset all outputs are 0, the FSM is in IDLE, and x, y and frame_cnt are 0. Reset asserted mid-frame drops the outputs to 0 immediately; after release the generator restarts from IDLE.
- FSM states: IDLE, VSYNC, VFP, ACTIVE, HBLK.
  - IDLE -> VSYNC when enable=1.
  - VSYNC lasts VSYNC_CLK clocks, then VFP.
  - VFP lasts VFP_CLK clocks, then ACTIVE with x=0, y=0.
  - ACTIVE lasts WIDTH clocks, x counting 0..WIDTH-1, then HBLK.
  - HBLK lasts HBLANK clocks. If y<HEIGHT-1: y++, x=0, go to ACTIVE. Otherwise end of frame: go to VSYNC if enable=1, else IDLE.
- Frame period is VSYNC_CLK + VFP_CLK + HEIGHT*(WIDTH+HBLANK) clocks. Back-to-back frames have no gap.
- enable is sampled only in IDLE and at end of frame. Deasserting it mid-frame lets the current frame finish.
- pattern_mode, solid_val and black_* are latched on entry to VSYNC. Changes mid-frame take effect from the next frame.
- Base value per pixel:
  - mode 0: solid_val
  - mode 1: x[BITS-1:0]
  - mode 2: y[BITS-1:0]
  - mode 3: all ones if x[3]^y[3], else 0
- Channel select is BAYER ^ {y[0], x[0]}: 0 selects black_r, 1 black_gr, 2 black_gb, 3 black_b.
- out_raw = min(base + black_ch, 2^BITS-1). The sum is computed at BITS+1 width and saturated.
- All outputs are registered, with one clock of latency from state/counter to pins:
  - out_href=1 exactly for the registered ACTIVE cycles.
  - out_vsync=1 exactly for the registered VSYNC cycles.
  - out_href and out_vsync are never high together.
- The first out_vsync rises on the 2nd rising edge after enable is observed high in IDLE.
- frame_done is high for one clock, aligned with the output cycle of the last HBLK clock of line HEIGHT-1. frame_cnt increments in the same clock.
- Widths: x and y counters are sized clog2(WIDTH) and clog2(HEIGHT); the blanking counter is sized to the largest of VSYNC_CLK, VFP_CLK and HBLANK. Parameters must all be ≥1.

Test Plan:
All scenarios use BITS=8, WIDTH=8, HEIGHT=4, HBLANK=2, VSYNC_CLK=2, VFP_CLK=3, BAYER=0.
- Mode 1, all black=0, enable held high -> each line outputs 0..7 with href high 8 clocks then low 2; 4 lines per frame; vsync high 2 clocks; frame period 45 clocks; one frame_done per frame; frame_cnt=1 after frame 1.
- Mode 0, solid=100, black_r=10, gr=20, gb=30, b=40 -> even lines 110,120,110,...; odd lines 130,140,130,...; with BAYER=3, even lines are 140,130,...
- Mode 0, solid=250, black_r=10 -> R pixels 255 (saturated), Gr pixels 255, and with black_gr=0 Gr pixels 250.
- Deassert enable during line 2 -> frame completes all 4 lines and frame_done pulses; no further vsync; outputs stay 0. Re-enable -> vsync after 2 clocks.
- Change pattern_mode 1->3 mid-frame -> the remaining lines stay a ramp; the next frame is a checker (all values 0 at this size, since x,y<8).
- Assert rst_n=0 mid-line -> href, vsync, raw, frame_done and frame_cnt are 0 asynchronously; after release, no href appears before a full vsync + VFP sequence.

Source files
------------

// File: rtl/isp_tpg.sv
// Bayer test-pattern and sensor-timing generator.
// Produces raw frames (vsync pulse, vertical front porch, then HEIGHT lines
// of WIDTH active pixels each followed by HBLANK blank clocks) carrying one
// of four patterns plus a per-CFA-channel black pedestal, saturated to BITS.
//
// Output interface: a source-only stream with no backpressure. out_href
// qualifies out_raw; a pixel is transferred on every rising pclk edge where
// out_href=1, and out_raw is held at 0 whenever out_href=0. out_vsync marks
// the start of a frame and is never high together with out_href.
module isp_tpg #(
   parameter int BITS      = 8,
   parameter int WIDTH     = 1280,
   parameter int HEIGHT    = 960,
   parameter int BAYER     = 0,
   parameter int VSYNC_CLK = 4,
   parameter int VFP_CLK   = 8,
   parameter int HBLANK    = 16
) (
   input  logic            pclk,
   input  logic            rst_n,
   input  logic            enable,
   input  logic [1:0]      pattern_mode,
   input  logic [BITS-1:0] solid_val,
   input  logic [BITS-1:0] black_r,
   input  logic [BITS-1:0] black_gr,
   input  logic [BITS-1:0] black_gb,
   input  logic [BITS-1:0] black_b,
   output logic            out_href,
   output logic            out_vsync,
   output logic [BITS-1:0] out_raw,
   output logic            frame_done,
   output logic [15:0]     frame_cnt
);

   localparam int XW     = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW     = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
   localparam int BMAX_A = (VSYNC_CLK > VFP_CLK) ? VSYNC_CLK : VFP_CLK;
   localparam int BMAX   = (BMAX_A > HBLANK) ? BMAX_A : HBLANK;
   localparam int BW     = (BMAX > 1) ? $clog2(BMAX) : 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_VSYNC  = 3'd1,
      S_VFP    = 3'd2,
      S_ACTIVE = 3'd3,
      S_HBLK   = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [XW-1:0]   x, x_nx;
   logic [YW-1:0]   y, y_nx;
   logic [BW-1:0]   bcnt, bcnt_nx;
   logic            frame_end;
   logic            load_cfg;

   // Per-frame configuration snapshot
   logic [1:0]      cfg_mode;
   logic [BITS-1:0] cfg_solid;
   logic [BITS-1:0] cfg_br, cfg_bgr, cfg_bgb, cfg_bb;

   // Pixel datapath
   logic            x_b3, y_b3;
   logic [BITS-1:0] base;
   logic [BITS-1:0] blk;
   logic [1:0]      ch;
   logic [BITS:0]   sum;
   logic [BITS-1:0] pix;

   // State and counter registers
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         x     <= '0;
         y     <= '0;
         bcnt  <= '0;
      end else begin
         state <= state_nx;
         x     <= x_nx;
         y     <= y_nx;
         bcnt  <= bcnt_nx;
      end
   end

   // Next-state logic: one shared blanking counter times VSYNC, VFP and HBLK
   always_comb begin
      state_nx  = state;
      x_nx      = x;
      y_nx      = y;
      bcnt_nx   = bcnt;
      frame_end = 1'b0;
      load_cfg  = 1'b0;
      case (state)
         S_IDLE: begin
            if (enable) begin
               state_nx = S_VSYNC;
               bcnt_nx  = '0;
               load_cfg = 1'b1;
            end
         end
         S_VSYNC: begin
            if (bcnt == BW'(VSYNC_CLK - 1)) begin
               state_nx = S_VFP;
               bcnt_nx  = '0;
            end else begin
               bcnt_nx = bcnt + BW'(1);
            end
         end
         S_VFP: begin
            if (bcnt == BW'(VFP_CLK - 1)) begin
               state_nx = S_ACTIVE;
               bcnt_nx  = '0;
               x_nx     = '0;
               y_nx     = '0;
            end else begin
               bcnt_nx = bcnt + BW'(1);
            end
         end
         S_ACTIVE: begin
            if (x == XW'(WIDTH - 1)) begin
               state_nx = S_HBLK;
               bcnt_nx  = '0;
            end else begin
               x_nx = x + XW'(1);
            end
         end
         S_HBLK: begin
            if (bcnt == BW'(HBLANK - 1)) begin
               bcnt_nx = '0;
               if (y != YW'(HEIGHT - 1)) begin
                  y_nx     = y + YW'(1);
                  x_nx     = '0;
                  state_nx = S_ACTIVE;
               end else begin
                  // End of frame: enable is only looked at here and in IDLE
                  frame_end = 1'b1;
                  if (enable) begin
                     state_nx = S_VSYNC;
                     load_cfg = 1'b1;
                  end else begin
                     state_nx = S_IDLE;
                  end
               end
            end else begin
               bcnt_nx = bcnt + BW'(1);
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   // Snapshot pattern and pedestals on VSYNC entry so a frame is uniform
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_mode  <= '0;
         cfg_solid <= '0;
         cfg_br    <= '0;
         cfg_bgr   <= '0;
         cfg_bgb   <= '0;
         cfg_bb    <= '0;
      end else if (load_cfg) begin
         cfg_mode  <= pattern_mode;
         cfg_solid <= solid_val;
         cfg_br    <= black_r;
         cfg_bgr   <= black_gr;
         cfg_bgb   <= black_gb;
         cfg_bb    <= black_b;
      end
   end

   // Bit 3 of the counters drives the 8x8 checker; narrow counters read as 0
   if (XW > 3) begin : g_xb3
      assign x_b3 = x[3];
   end else begin : g_xb3_zero
      assign x_b3 = 1'b0;
   end
   if (YW > 3) begin : g_yb3
      assign y_b3 = y[3];
   end else begin : g_yb3_zero
      assign y_b3 = 1'b0;
   end

   // Pattern base, CFA pedestal select and saturating add
   always_comb begin
      case (cfg_mode)
         2'd0:    base = cfg_solid;
         2'd1:    base = BITS'(x);
         2'd2:    base = BITS'(y);
         default: base = (x_b3 ^ y_b3) ? {BITS{1'b1}} : {BITS{1'b0}};
      endcase
      ch = 2'(BAYER) ^ {y[0], x[0]};
      case (ch)
         2'd0:    blk = cfg_br;
         2'd1:    blk = cfg_bgr;
         2'd2:    blk = cfg_bgb;
         default: blk = cfg_bb;
      endcase
      sum = {1'b0, base} + {1'b0, blk};
      pix = sum[BITS] ? {BITS{1'b1}} : sum[BITS-1:0];
   end

   // Registered outputs, one clock behind state and counters
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         out_href   <= 1'b0;
         out_vsync  <= 1'b0;
         out_raw    <= '0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
      end else begin
         out_href   <= (state == S_ACTIVE);
         out_vsync  <= (state == S_VSYNC);
         out_raw    <= (state == S_ACTIVE) ? pix : '0;
         frame_done <= frame_end;
         if (frame_end) begin
            frame_cnt <= frame_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_isp_tpg.sv
// Bench for isp_tpg: two instances (CFA phase RGGB and BGGR) share stimulus.
// The driver issues frame configurations and pushes each frame's expected
// pixels into per-instance queues; a negedge monitor pops and compares every
// href pixel and checks frame timing against the configured geometry.
module tb_isp_tpg;

   localparam int BITS      = 8;
   localparam int WIDTH     = 8;
   localparam int HEIGHT    = 4;
   localparam int HBLANK    = 2;
   localparam int VSYNC_CLK = 2;
   localparam int VFP_CLK   = 3;
   localparam int FRAME_CLK = VSYNC_CLK + VFP_CLK + HEIGHT * (WIDTH + HBLANK);
   localparam int NF        = 10;   // back-to-back frames in the main run
   localparam int NSCRIPT   = 7;    // directed configurations before random ones

   // ---------------- clock / reset ----------------
   logic            pclk   = 1'b0;
   logic            rst_n  = 1'b0;
   logic            enable = 1'b0;
   logic [1:0]      pattern_mode = 2'd0;
   logic [BITS-1:0] solid_val = '0;
   logic [BITS-1:0] black_r = '0, black_gr = '0, black_gb = '0, black_b = '0;

   logic            out_href, out_vsync, frame_done;
   logic [BITS-1:0] out_raw;
   logic [15:0]     frame_cnt;
   logic            out_href3, out_vsync3, frame_done3;
   logic [BITS-1:0] out_raw3;
   logic [15:0]     frame_cnt3;

   always #5 pclk = ~pclk;

   isp_tpg #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(0),
             .VSYNC_CLK(VSYNC_CLK), .VFP_CLK(VFP_CLK), .HBLANK(HBLANK)) dut (
      .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern_mode(pattern_mode),
      .solid_val(solid_val), .black_r(black_r), .black_gr(black_gr),
      .black_gb(black_gb), .black_b(black_b), .out_href(out_href),
      .out_vsync(out_vsync), .out_raw(out_raw), .frame_done(frame_done),
      .frame_cnt(frame_cnt));

   isp_tpg #(.BITS(BITS), .WIDTH(WIDTH), .HEIGHT(HEIGHT), .BAYER(3),
             .VSYNC_CLK(VSYNC_CLK), .VFP_CLK(VFP_CLK), .HBLANK(HBLANK)) dut3 (
      .pclk(pclk), .rst_n(rst_n), .enable(enable), .pattern_mode(pattern_mode),
      .solid_val(solid_val), .black_r(black_r), .black_gr(black_gr),
      .black_gb(black_gb), .black_b(black_b), .out_href(out_href3),
      .out_vsync(out_vsync3), .out_raw(out_raw3), .frame_done(frame_done3),
      .frame_cnt(frame_cnt3));

   // ---------------- scoreboard state ----------------
   logic [BITS-1:0] exp_q0[$];
   logic [BITS-1:0] exp_q3[$];
   int checks = 0;
   int errors = 0;

   // Colour at (row parity, column parity): 0 R, 1 Gr, 2 Gb, 3 B
   int cfa_rggb [2][2] = '{'{0, 1}, '{2, 3}};
   int cfa_bggr [2][2] = '{'{3, 2}, '{1, 0}};

   // Directed configurations: mode, solid, R, Gr, Gb, B
   int scr [NSCRIPT][6] = '{
      '{1,   0,  0,  0,  0,  0},   // ramp, no pedestal
      '{0, 100, 10, 20, 30, 40},   // solid + distinct pedestals
      '{0, 250, 10, 10,  3,  0},   // R and Gr saturate
      '{0, 250, 10,  0,  6,  5},   // Gr unsaturated at 250
      '{1,   0,  5,  6,  7,  8},   // ramp with pedestal
      '{3,   0,  0,  0,  0,  0},   // checker (all zero at this size)
      '{2,   0, 50, 60, 70, 80}    // vertical ramp
   };

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic push_frame(input int mode, input int solid, input int br,
                             input int bgr, input int bgb, input int bb);
      int blk[4];
      int base, v0, v3;
      blk = '{br, bgr, bgb, bb};
      for (int yy = 0; yy < HEIGHT; yy++) begin
         for (int xx = 0; xx < WIDTH; xx++) begin
            case (mode)
               0: base = solid;
               1: base = xx % 256;
               2: base = yy % 256;
               default: base = (((xx / 8) % 2) != ((yy / 8) % 2)) ? 255 : 0;
            endcase
            v0 = base + blk[cfa_rggb[yy % 2][xx % 2]];
            v3 = base + blk[cfa_bggr[yy % 2][xx % 2]];
            if (v0 > 255) v0 = 255;
            if (v3 > 255) v3 = 255;
            exp_q0.push_back(BITS'(v0));
            exp_q3.push_back(BITS'(v3));
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic apply_cfg(input int mode, input int solid, input int br,
                            input int bgr, input int bgb, input int bb);
      pattern_mode = 2'(mode);
      solid_val    = BITS'(solid);
      black_r      = BITS'(br);
      black_gr     = BITS'(bgr);
      black_gb     = BITS'(bgb);
      black_b      = BITS'(bb);
      push_frame(mode, solid, br, bgr, bgb, bb);
   endtask

   task automatic apply_random();
      apply_cfg($urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
   endtask

   task automatic wait_vsync_rise(input string name);
      int n = 0;
      while (out_vsync && n < 200) begin @(negedge pclk); n++; end
      while (!out_vsync && n < 200) begin @(negedge pclk); n++; end
      check(name, out_vsync, 1);
   endtask

   // ---------------- monitor ----------------
   int frames_seen = 0, model_fcnt = 0;
   int vs_len = 0, hr_len = 0, lo_len = 0, since_fall = 0, since_vs = 0, lines = 0;
   bit prev_vs = 0, prev_hr = 0, prev_fd = 0, in_frame = 0, first_line = 0;

   task automatic wait_frames(input int target, input string name);
      int n = 0;
      while (frames_seen < target && n < 200) begin @(negedge pclk); n++; end
      check(name, frames_seen, target);
   endtask

   always @(negedge pclk) begin
      if (!rst_n) begin
         check("rst_href", out_href, 0);
         check("rst_vsync", out_vsync, 0);
         check("rst_raw", out_raw, 0);
         check("rst_frame_done", frame_done, 0);
         check("rst_frame_cnt", frame_cnt, 0);
         frames_seen = 0; model_fcnt = 0;
         vs_len = 0; hr_len = 0; lo_len = 0; since_fall = 0; since_vs = 0; lines = 0;
         prev_vs = 0; prev_hr = 0; prev_fd = 0; in_frame = 0; first_line = 0;
      end else begin
         check("href_vsync_excl", out_href & out_vsync, 0);
         check("bggr_href_align", out_href3, out_href);
         check("bggr_vsync_align", out_vsync3, out_vsync);
         check("bggr_done_align", frame_done3, frame_done);
         check("bggr_frame_cnt", frame_cnt3, model_fcnt + (frame_done ? 1 : 0));
         if (!out_href)  check("raw_blank", out_raw, 0);
         if (!out_href3) check("raw3_blank", out_raw3, 0);

         // line timing
         if (out_href && !prev_hr) begin
            check("href_in_frame", in_frame, 1);
            if (first_line) check("vfp_gap", since_fall, VFP_CLK);
            else            check("hblank_gap", lo_len, HBLANK);
            first_line = 0;
            lines++;
         end
         if (!out_href && prev_hr) check("href_len", hr_len, WIDTH);
         hr_len = out_href ? hr_len + 1 : 0;
         lo_len = out_href ? 0 : lo_len + 1;

         // frame timing
         if (out_vsync && !prev_vs) begin
            if (prev_fd) check("frame_period", since_vs, FRAME_CLK);
            since_vs = 1; in_frame = 1; first_line = 1; lines = 0;
         end else begin
            since_vs++;
         end
         if (!out_vsync && prev_vs) begin
            check("vsync_len", vs_len, VSYNC_CLK);
            since_fall = 1;
         end else if (!out_vsync) begin
            since_fall++;
         end
         vs_len = out_vsync ? vs_len + 1 : 0;

         // pixels
         if (out_href) begin
            check("pix_rggb_queued", int'(exp_q0.size() > 0), 1);
            if (exp_q0.size() > 0) check("pix_rggb", out_raw, exp_q0.pop_front());
         end
         if (out_href3) begin
            check("pix_bggr_queued", int'(exp_q3.size() > 0), 1);
            if (exp_q3.size() > 0) check("pix_bggr", out_raw3, exp_q3.pop_front());
         end

         // end of frame
         if (frame_done) begin
            check("fd_in_frame", in_frame, 1);
            check("fd_single", prev_fd, 0);
            check("lines_per_frame", lines, HEIGHT);
            check("fd_after_hblank", lo_len, HBLANK);
            model_fcnt = (model_fcnt + 1) % 65536;
            frames_seen++;
            in_frame = 0;
         end
         check("frame_cnt", frame_cnt, model_fcnt);

         prev_vs = out_vsync;
         prev_hr = out_href;
         prev_fd = frame_done;
      end
   end

   // ---------------- main sequence ----------------
   initial begin
      int n, bad;
      rst_n  = 1'b0;
      enable = 1'b0;
      repeat (3) @(negedge pclk);
      @(negedge pclk) rst_n = 1'b1;
      // Enable low: generator must stay silent
      repeat (4) @(negedge pclk) check("idle_no_vsync", out_vsync, 0);

      // Start: first vsync on the second rising edge after enable
      apply_cfg(scr[0][0], scr[0][1], scr[0][2], scr[0][3], scr[0][4], scr[0][5]);
      enable = 1'b1;
      @(negedge pclk) check("start_edge1_vsync", out_vsync, 0);
      @(negedge pclk) check("start_edge2_vsync", out_vsync, 1);

      // Back-to-back frames; next config lands at a random point mid-frame
      for (int k = 1; k < NF; k++) begin
         repeat ($urandom_range(0, 38)) @(negedge pclk);
         if (k < NSCRIPT) apply_cfg(scr[k][0], scr[k][1], scr[k][2], scr[k][3], scr[k][4], scr[k][5]);
         else             apply_random();
         wait_vsync_rise("frame_start");
      end

      // Drop enable during line 2 of the last frame: it must still complete
      repeat ($urandom_range(25, 33)) @(negedge pclk);
      enable = 1'b0;
      wait_frames(NF, "frames_completed");
      bad = 0;
      repeat (50) @(negedge pclk) if (out_vsync || out_href) bad++;
      check("stay_idle_after_disable", bad, 0);
      check("queue_rggb_drained", exp_q0.size(), 0);
      check("queue_bggr_drained", exp_q3.size(), 0);
      check("frame_cnt_total", frame_cnt, NF);

      // Re-enable from IDLE
      apply_random();
      enable = 1'b1;
      @(negedge pclk) check("reen_edge1_vsync", out_vsync, 0);
      @(negedge pclk) check("reen_edge2_vsync", out_vsync, 1);
      repeat ($urandom_range(0, 38)) @(negedge pclk);
      apply_random();
      wait_vsync_rise("reen_second_frame");

      // Reset in the middle of a line
      repeat ($urandom_range(6, 30)) @(negedge pclk);
      n = 0;
      while (!out_href && n < 100) begin @(negedge pclk); n++; end
      check("href_before_reset", out_href, 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_href", out_href, 0);
      check("async_rst_vsync", out_vsync, 0);
      check("async_rst_raw", out_raw, 0);
      check("async_rst_frame_done", frame_done, 0);
      check("async_rst_frame_cnt", frame_cnt, 0);
      exp_q0.delete();
      exp_q3.delete();
      repeat (2) @(negedge pclk);
      apply_random();
      rst_n = 1'b1;
      @(negedge pclk) check("rst_rel_edge1_vsync", out_vsync, 0);
      @(negedge pclk) check("rst_rel_edge2_vsync", out_vsync, 1);
      enable = 1'b0;
      wait_frames(1, "frame_after_reset");
      repeat (10) @(negedge pclk);
      check("post_reset_vsync_idle", out_vsync, 0);
      check("post_reset_queue_drained", exp_q0.size(), 0);
      check("post_reset_frame_cnt", frame_cnt, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Watchdog so a stuck design can never hang the run
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
